// File: rtl/multiport_sram_ctrl.sv
// rtl/multiport_sram_ctrl.sv - multi-requester controller for an asynchronous SRAM
// Define SRAM_RR_ARB_EN for round-robin arbitration; default build is fixed priority (lowest index wins).

module multiport_sram_ctrl #(
  parameter int N_PORTS     = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS-1:0]              req,
  input  logic [N_PORTS-1:0]              we,
  input  logic [N_PORTS*ADDR_W-1:0]       addr,
  input  logic [N_PORTS*DATA_W-1:0]       wdata,
  input  logic [N_PORTS*(DATA_W/8)-1:0]   be,
  output logic [N_PORTS-1:0]              ack,
  output logic [DATA_W-1:0]               rdata,
  output logic [ADDR_W-1:0]               sram_addr,
  output logic                            sram_ce_n,
  output logic                            sram_oe_n,
  output logic                            sram_we_n,
  output logic [DATA_W/8-1:0]             sram_be_n,
  output logic [DATA_W-1:0]               sram_data_o,
  output logic                            sram_data_oe,
  input  logic [DATA_W-1:0]               sram_data_i
);

  localparam int BE_W   = DATA_W / 8;
  localparam int PIDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PIDX_W-1:0]   sel_q, sel_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [BE_W-1:0]     be_q, be_d;

  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   sram_data_o_q, sram_data_o_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [BE_W-1:0]     be_n_q, be_n_d;
  logic                doe_q, doe_d;
  logic [N_PORTS-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                grant_vld;
  logic [PIDX_W-1:0]   grant_idx;

`ifdef SRAM_RR_ARB_EN
  logic [PIDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Walk from farthest to nearest so the port right after the last grant wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      if (req[(int'(rr_ptr_q) + k) % N_PORTS]) begin
        grant_vld = 1'b1;
        grant_idx = PIDX_W'((int'(rr_ptr_q) + k) % N_PORTS);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && grant_vld) begin
      rr_ptr_d = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= PIDX_W'(N_PORTS - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant_vld = 1'b1;
        grant_idx = PIDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          sel_d   = grant_idx;
          wr_d    = we[grant_idx];
          addr_d  = addr[grant_idx*ADDR_W +: ADDR_W];
          wdat_d  = wdata[grant_idx*DATA_W +: DATA_W];
          be_d    = be[grant_idx*BE_W +: BE_W];
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The SRAM bus, ack and rdata are registered from the current state, so they
  // trail the FSM by one cycle; rdata is sampled while the bus is still in ACCESS.
  always_comb begin
    sram_addr_d   = sram_addr_q;
    sram_data_o_d = sram_data_o_q;
    ce_n_d        = 1'b1;
    oe_n_d        = 1'b1;
    we_n_d        = 1'b1;
    be_n_d        = '1;
    doe_d         = 1'b0;
    ack_d         = '0;
    rdata_d       = rdata_q;
    case (state_q)
      ACCESS: begin
        sram_addr_d   = addr_q;
        sram_data_o_d = wdat_q;
        ce_n_d        = 1'b0;
        oe_n_d        = wr_q;
        we_n_d        = ~wr_q;
        be_n_d        = ~be_q;
        doe_d         = wr_q;
      end
      DONE: begin
        doe_d        = wr_q;
        ack_d[sel_q] = 1'b1;
        if (!wr_q) begin
          rdata_d = sram_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sel_q         <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdat_q        <= '0;
      be_q          <= '0;
      sram_addr_q   <= '0;
      sram_data_o_q <= '0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      be_n_q        <= '1;
      doe_q         <= 1'b0;
      ack_q         <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdat_q        <= wdat_d;
      be_q          <= be_d;
      sram_addr_q   <= sram_addr_d;
      sram_data_o_q <= sram_data_o_d;
      ce_n_q        <= ce_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      be_n_q        <= be_n_d;
      doe_q         <= doe_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
    end
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign sram_addr    = sram_addr_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_be_n    = be_n_q;
  assign sram_data_o  = sram_data_o_q;
  assign sram_data_oe = doe_q;

endmodule

// File: doc/multiport_sram_ctrl.md
MULTIPORT_SRAM_CTRL -- requirements
Module: multiport_sram_ctrl

Interface
REQ-001 Parameter N_PORTS, 2, number of requester ports (range 1..8).
REQ-002 Parameter DATA_W, 32, SRAM data width; byte enables are DATA_W/8 bits.
REQ-003 Parameter ADDR_W, 20, SRAM word address width.
REQ-004 Parameter WAIT_CYCLES, 1, extra access cycles beyond the minimum (range 0..15).
REQ-005 clk  in  1  controller clock.
REQ-006 rst  in  1  reset: asynchronous, active-high.
REQ-007 req  in  N_PORTS  per-port access request, held until ack.
REQ-008 we  in  N_PORTS  per-port write (1) or read (0).
REQ-009 addr  in  N_PORTS*ADDR_W  per-port word address, port p at bits [p*ADDR_W +: ADDR_W].
REQ-010 wdata  in  N_PORTS*DATA_W  per-port write data, packed the same way.
REQ-011 be  in  N_PORTS*DATA_W/8  per-port active-high byte enables.
REQ-012 ack  out  N_PORTS  one-cycle completion pulse per port.
REQ-013 rdata  out  DATA_W  shared read data, valid in the ack cycle.
REQ-014 sram_addr  out  ADDR_W; sram_ce_n, sram_oe_n, sram_we_n  out  1 each; sram_be_n  out  DATA_W/8.
REQ-015 sram_data_o  out  DATA_W; sram_data_oe  out  1; sram_data_i  in  DATA_W (tri-state resolved at top level).

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and DONE, and all SRAM outputs SHALL be registered.
REQ-017 IDLE: if any req bit is set, the controller SHALL latch the winning port's we/addr/wdata/be, drive the pins on the next edge, load the counter with WAIT_CYCLES, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-018 ACCESS: ce_n=0; reads oe_n=0, we_n=1, data_oe=0; writes oe_n=1, we_n=0, data_oe=1; be_n=~be.
REQ-019 ACCESS SHALL last WAIT_CYCLES+1 cycles, with the counter decrementing each cycle, and SHALL exit to DONE when the counter reaches 0.
REQ-020 On the ACCESS->DONE edge, reads SHALL capture sram_data_i into rdata; writes SHALL leave rdata unchanged.
REQ-021 DONE: ack[winner]=1 for exactly one cycle; we_n=1, oe_n=1, ce_n=1; address and data_oe (writes) held for hold time; next state IDLE.
REQ-022 Latency: req sampled in IDLE at cycle T -> ack at T+WAIT_CYCLES+3; back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
REQ-023 In IDLE: ce_n=oe_n=we_n=1, be_n all 1, data_oe=0.
REQ-024 Requests arriving during ACCESS/DONE SHALL wait; a requester dropping req mid-access SHALL not abort it, and ack still pulses.
REQ-025 At most one ack bit SHALL be high in any cycle; ack SHALL never pulse for a port that was not granted.
REQ-026 A requester SHALL keep req asserted after its ack only for a new access; the controller SHALL treat req high in the IDLE following DONE as a new request.

Reset
REQ-027 On rst: state=IDLE, counter=0, ack=0, rdata=0, pins per REQ-023, sram_addr=0, sram_data_o=0, round-robin pointer=N_PORTS-1.
REQ-028 rst asserted mid-ACCESS SHALL immediately deassert we_n/oe_n/ce_n and data_oe, and no ack SHALL be issued for the aborted access.

Configuration
REQ-029 Macro SRAM_RR_ARB_EN defined: round-robin arbitration; the search starts at (last_grant+1) mod N_PORTS, and the pointer updates on each grant.
REQ-030 SRAM_RR_ARB_EN undefined: fixed priority with the lowest index winning, and no pointer register.

Verification
REQ-031 WAIT_CYCLES=1, port0 read addr 0x00010 with sram_data_i=0xDEADBEEF -> ack[0] at T+4, rdata=0xDEADBEEF, oe_n low for 2 cycles.
REQ-032 Port1 write addr 0x00020, wdata 0x12345678, be 4'b0011 -> we_n low 2 cycles, be_n=4'b1100, sram_data_o=0x12345678, data_oe high through DONE, ack[1] once.
REQ-033 Both ports request continuously with RR: grants 0,1,0,1; with RR undefined: grants 0,0,0, and port1 is served only after req[0] drops.
REQ-034 WAIT_CYCLES=0 and 15: ack at T+3 and T+18 respectively.
REQ-035 rst pulsed during the second ACCESS cycle of a write -> we_n=1 and data_oe=0 asynchronously, no ack, and the next request after reset is served normally.
